regs_seq_ctrl: RTL and testbench
================================

# regs_seq_ctrl

Job sequencer that sits between the generated register block and the processing datapath. A write of START.val launches a job: the sequencer issues CTRL.val requests to the datapath over a valid/ready handshake and accumulates the responses. It reports progress and result through STATUS.val and a result register, and raises a one-cycle completion interrupt.

## Interface
- `CNT_W`, 16: width of the iteration count; matches CTRL.val.
- `DATA_W`, 32: operand, response and accumulator width; matches DATA.val.
- `TIMEOUT_CYCLES`, 1024: maximum wait cycles per response. Used only when the timeout feature is compiled in.
- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start_pulse`  in  1  one-cycle strobe from the write to START.val.
- `abort`  in  1  level; cancels a running job.
- `ctrl_val`  in  CNT_W  iteration count (CTRL.val, reset 0x100).
- `data_val`  in  DATA_W  base operand (DATA.val).
- `status_val`  out  8  STATUS.val image.
- `result`  out  DATA_W  accumulated response sum.
- `req_valid`  out  1  request to datapath.
- `req_ready`  in  1  datapath accepts request.
- `req_data`  out  DATA_W  operand for current iteration.
- `req_idx`  out  CNT_W  current iteration index.
- `rsp_valid`  in  1  datapath response strobe.
- `rsp_data`  in  DATA_W  response payload.
- `rsp_err`  in  1  response error flag, qualified by rsp_valid.
- `irq`  out  1  one-cycle pulse at job end.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE + start_pulse:
  - latch count ← ctrl_val and base ← data_val.
  - clear idx, result, done, err, timeout, aborted and err_cnt.
  - go to ISSUE, or to DONE if count == 0.
- ISSUE:
  - req_valid=1, req_data=base+idx (mod 2^DATA_W), req_idx=idx.
  - Outputs are held stable until req_ready.
  - On req_valid&&req_ready, go to WAIT.
- WAIT: on rsp_valid:
  - result ← result+rsp_data (wraps).
  - if rsp_err: set err; err_cnt saturates at 7.
  - if idx==count-1, go to DONE; else idx++ and go to ISSUE.
- DONE: set done, pulse irq, go to IDLE.
- rsp_valid outside WAIT is ignored.
- start_pulse outside IDLE is ignored; the latched job is unaffected.
- abort in ISSUE/WAIT/DONE:
  - go to IDLE next cycle; set aborted; no irq.
  - req_valid drops the cycle after abort is sampled.
  - abort has priority over all simultaneous events.
- abort in IDLE has no effect.
- STATUS.val bits:
  - [0] busy (state≠IDLE)
  - [1] done
  - [2] err
  - [3] timeout
  - [4] aborted
  - [7:5] err_cnt
  - done/err/timeout/aborted/err_cnt are sticky until the next accepted start.
- Reset values: all outputs 0, state IDLE, internal registers 0.

## Timing
- start_pulse at cycle T: busy=1 and req_valid=1 at T+1.
- count==0: irq and done at T+2; no request is issued.
- Request accepted at cycle R: WAIT from R+1. A response can be accepted at R+1 at the earliest.
- Response at cycle S: next req_valid at S+1, or irq at S+1 for the last iteration.
- Minimum iteration period: 2 cycles.
- irq is high for exactly one cycle. busy falls in the cycle after irq.
- Asserting reset mid-job returns to IDLE immediately and clears all sticky bits.

## Configuration
- `REGS_SEQ_TIMEOUT_EN` defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without rsp_valid: set timeout and err, go to DONE (irq fires).
  - rsp_valid in the same cycle as expiry wins; the response is taken normally.
- Not defined: no counter is instantiated, WAIT waits indefinitely, and STATUS[3] is tied to 0.

## Structure
- `regs_seq_pkg` contains:
  - the state enum type;
  - STATUS bit-index constants (BUSY_BIT=0 … ERRCNT_LSB=5);
  - ERRCNT_MAX=7.
- One sub-module, `regs_seq_timeout`:
  - inputs: clear and enable.
  - output: expired.
  - instantiated only under REGS_SEQ_TIMEOUT_EN.

## Test plan
- Basic job: ctrl_val=3, data_val=0x10, req_ready=1, each response rsp_data=idx+1, no errors → req_data 0x10/0x11/0x12, result=6, STATUS=0x02 after job, one irq.
- Zero count: ctrl_val=0, start → no req_valid, irq at T+2, STATUS=0x02.
- Backpressure and errors:
  - req_ready held low 5 cycles → req_data/req_idx stay stable;
  - ctrl_val=9, rsp_err on every response → err_cnt saturates, STATUS=0xE6.
- Abort mid-WAIT with ctrl_val=4 after 2 responses:
  - → IDLE, STATUS=0x10, no irq;
  - a new start clears STATUS and idx restarts at 0.
- Timeout (macro defined, TIMEOUT_CYCLES=8):
  - no response → irq 8 cycles after WAIT entry, STATUS=0x0E;
  - rsp_valid on the expiry cycle → normal completion with STATUS=0x02.
- Reset asserted during ISSUE → req_valid, busy and irq are 0 immediately; start_pulse while busy is ignored.

Source files
------------

// File: rtl/regs_seq_pkg.sv
// regs_seq_pkg: shared types and constants for the job sequencer.
//   state_e      : sequencer FSM state
//   *_BIT / LSB  : STATUS.val bit positions
//   ERRCNT_MAX   : saturation value of the error counter
package regs_seq_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   localparam int BUSY_BIT    = 0;
   localparam int DONE_BIT    = 1;
   localparam int ERR_BIT     = 2;
   localparam int TIMEOUT_BIT = 3;
   localparam int ABORT_BIT   = 4;
   localparam int ERRCNT_LSB  = 5;

   localparam logic [2:0] ERRCNT_MAX = 3'd7;

endpackage

// File: rtl/regs_seq_timeout.sv
// regs_seq_timeout: per-response wait counter.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : zero the counter (on entry to WAIT)
//   enable   : count this cycle (in WAIT)
//   expired  : high in the TIMEOUT_CYCLES-th WAIT cycle
module regs_seq_timeout #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Cycle 0 of WAIT sees cnt_q==0, so the Nth WAIT cycle sees N-1.
   assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && !expired)
         cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/regs_seq_ctrl.sv
// regs_seq_ctrl: job sequencer between the register block and the datapath.
// A START.val strobe latches CTRL.val/DATA.val, then one request per iteration
// is issued over req_valid/req_ready and each response is summed into result.
//   start_pulse, abort       : job control
//   ctrl_val, data_val       : iteration count, base operand
//   status_val, result, irq  : STATUS.val image, response sum, completion pulse
//   req_*                    : request channel to the datapath
//   rsp_*                    : response channel from the datapath
// Optional feature macro: REGS_SEQ_TIMEOUT_EN (per-response wait timeout).
module regs_seq_ctrl
   import regs_seq_pkg::*;
#(
   parameter int CNT_W          = 16,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_pulse,
   input  logic              abort,
   input  logic [CNT_W-1:0]  ctrl_val,
   input  logic [DATA_W-1:0] data_val,
   output logic [7:0]        status_val,
   output logic [DATA_W-1:0] result,
   output logic              req_valid,
   input  logic              req_ready,
   output logic [DATA_W-1:0] req_data,
   output logic [CNT_W-1:0]  req_idx,
   input  logic              rsp_valid,
   input  logic [DATA_W-1:0] rsp_data,
   input  logic              rsp_err,
   output logic              irq
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0] base_q, base_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              timeout_q, timeout_d;
   logic              aborted_q, aborted_d;
   logic [2:0]        err_cnt_q, err_cnt_d;
   logic              expired;

`ifdef REGS_SEQ_TIMEOUT_EN
   regs_seq_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   ((state_q == S_ISSUE) && req_ready && !abort && (count_q != '0)),
      .enable  (state_q == S_WAIT),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   // A zero-count job still spends one cycle in ISSUE (req_valid held low),
   // so its completion lands two cycles after the start strobe.
   assign req_valid = (state_q == S_ISSUE) && (count_q != '0);
   assign req_data  = base_q + DATA_W'(idx_q);
   assign req_idx   = idx_q;
   assign result    = result_q;

   always_comb begin
      status_val                  = '0;
      status_val[BUSY_BIT]        = (state_q != S_IDLE);
      status_val[DONE_BIT]        = done_q;
      status_val[ERR_BIT]         = err_q;
      status_val[TIMEOUT_BIT]     = timeout_q;
      status_val[ABORT_BIT]       = aborted_q;
      status_val[ERRCNT_LSB +: 3] = err_cnt_q;
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      idx_d     = idx_q;
      base_d    = base_q;
      result_d  = result_q;
      done_d    = done_q;
      err_d     = err_q;
      timeout_d = timeout_q;
      aborted_d = aborted_q;
      err_cnt_d = err_cnt_q;
      irq       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_pulse) begin
               count_d   = ctrl_val;
               base_d    = data_val;
               idx_d     = '0;
               result_d  = '0;
               done_d    = 1'b0;
               err_d     = 1'b0;
               timeout_d = 1'b0;
               aborted_d = 1'b0;
               err_cnt_d = '0;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_IDLE;
            end else if (count_q == '0) begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end else if (req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort) begin
               aborted_d = 1'b1;
               state_d   = S_IDLE;
            end else if (rsp_valid) begin
               // A response arriving on the expiry cycle is taken normally.
               result_d = result_q + rsp_data;
               if (rsp_err) begin
                  err_d = 1'b1;
                  if (err_cnt_q != ERRCNT_MAX) err_cnt_d = err_cnt_q + 3'd1;
               end
               if (idx_q == count_q - CNT_W'(1)) begin
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + CNT_W'(1);
                  state_d = S_ISSUE;
               end
            end else if (expired) begin
               timeout_d = 1'b1;
               err_d     = 1'b1;
               done_d    = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            // An abort here cancels the completion: no irq, done withdrawn.
            if (abort) begin
               aborted_d = 1'b1;
               done_d    = 1'b0;
            end else begin
               irq = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

`ifndef REGS_SEQ_TIMEOUT_EN
      timeout_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         idx_q     <= '0;
         base_q    <= '0;
         result_q  <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         timeout_q <= 1'b0;
         aborted_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         base_q    <= base_d;
         result_q  <= result_d;
         done_q    <= done_d;
         err_q     <= err_d;
         timeout_q <= timeout_d;
         aborted_q <= aborted_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_regs_seq_ctrl.sv
// tb_regs_seq_ctrl: scoreboard bench for regs_seq_ctrl. Stimulus pushes the
// expected request beats and job results into queues; a negedge monitor pops
// and compares on every request handshake and every irq.
// Timeout cases are built when REGS_SEQ_TIMEOUT_EN is defined.
module tb_regs_seq_ctrl;

   localparam int CNT_W  = 16;
   localparam int DATA_W = 32;
`ifdef REGS_SEQ_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 1024;
`endif

   logic              clk = 1'b0, rst = 1'b0;
   logic              start_pulse = 1'b0, abort = 1'b0;
   logic [CNT_W-1:0]  ctrl_val = 16'h0100;
   logic [DATA_W-1:0] data_val = '0;
   logic [7:0]        status_val;
   logic [DATA_W-1:0] result;
   logic              req_valid;
   logic              req_ready = 1'b0;
   logic [DATA_W-1:0] req_data;
   logic [CNT_W-1:0]  req_idx;
   logic              rsp_valid = 1'b0;
   logic [DATA_W-1:0] rsp_data = '0;
   logic              rsp_err = 1'b0;
   logic              irq;

   regs_seq_ctrl #(.CNT_W(CNT_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .start_pulse(start_pulse), .abort(abort),
      .ctrl_val(ctrl_val), .data_val(data_val), .status_val(status_val),
      .result(result), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .req_idx(req_idx), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [CNT_W-1:0]  idx;
   } req_t;

   req_t              req_q[$];
   logic [DATA_W-1:0] job_q[$];
   int n_tests = 0, n_fail = 0, irq_cnt = 0, irq0 = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_req(input logic [DATA_W-1:0] d, input logic [CNT_W-1:0] i);
      req_t r;
      r.data = d;
      r.idx  = i;
      req_q.push_back(r);
   endtask

   // Monitor: compares DUT outputs against the scoreboard queues.
   always @(negedge clk) begin
      if (rst) begin
         if (req_valid && req_ready) begin
            if (req_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL req_unexpected: got idx %0d data %0h expected no request", req_idx, req_data);
            end else begin
               req_t e;
               e = req_q.pop_front();
               chk("req_data", {32'd0, req_data}, {32'd0, e.data});
               chk("req_idx", {48'd0, req_idx}, {48'd0, e.idx});
            end
         end
         if (irq) begin
            irq_cnt++;
            if (job_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL irq_unexpected: got irq with result %0h expected no irq", result);
            end else begin
               logic [DATA_W-1:0] er;
               er = job_q.pop_front();
               chk("irq_result", {32'd0, result}, {32'd0, er});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [CNT_W-1:0] cnt, input logic [DATA_W-1:0] base);
      ctrl_val    = cnt;
      data_val    = base;
      start_pulse = 1'b1;
      tick();
      start_pulse = 1'b0;
   endtask

   // Acts as the datapath for n iterations. The first request is held off
   // for 'stall' cycles while its payload is checked for stability.
   task automatic serve(input int n, input logic [DATA_W-1:0] rbase,
                        input logic [DATA_W-1:0] rinc, input logic err, input int stall);
      for (int i = 0; i < n; i++) begin
         int w;
         w = 0;
         while (!req_valid && w < 50) begin tick(); w++; end
         if (!req_valid) begin
            chk("req_valid_wait", 64'd0, 64'd1);
            return;
         end
         if (i == 0) begin
            for (int s = 0; s < stall; s++) begin
               tick();
               chk("stall_valid", {63'd0, req_valid}, 64'd1);
               if (req_q.size() != 0) begin
                  chk("stall_data", {32'd0, req_data}, {32'd0, req_q[0].data});
                  chk("stall_idx", {48'd0, req_idx}, {48'd0, req_q[0].idx});
               end
            end
         end
         req_ready = 1'b1;
         tick();
         req_ready = 1'b0;
         rsp_valid = 1'b1;
         rsp_data  = rbase + DATA_W'(i) * rinc;
         rsp_err   = err;
         tick();
         rsp_valid = 1'b0;
         rsp_err   = 1'b0;
         rsp_data  = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #3;
      chk("rst_status", {56'd0, status_val}, 64'd0);
      chk("rst_result", {32'd0, result}, 64'd0);
      chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
      chk("rst_irq", {63'd0, irq}, 64'd0);
      tick();
      rst = 1'b1;
      tick();

      // Basic job: 3 iterations, responses idx+1
      push_req(32'h10, 16'd0); push_req(32'h11, 16'd1); push_req(32'h12, 16'd2);
      job_q.push_back(32'd6);
      irq0 = irq_cnt;
      do_start(16'd3, 32'h10);
      chk("basic_busy", {63'd0, status_val[0]}, 64'd1);
      chk("basic_req_valid", {63'd0, req_valid}, 64'd1);
      serve(3, 32'd1, 32'd1, 1'b0, 0);
      chk("basic_irq", {63'd0, irq}, 64'd1);
      tick();
      chk("basic_status", {56'd0, status_val}, 64'h02);
      chk("basic_result", {32'd0, result}, 64'd6);
      chk("basic_irqs", 64'(irq_cnt - irq0), 64'd1);

      // Zero count
      job_q.push_back(32'd0);
      irq0 = irq_cnt;
      do_start(16'd0, 32'h55);
      chk("zero_req_valid", {63'd0, req_valid}, 64'd0);
      chk("zero_busy", {63'd0, status_val[0]}, 64'd1);
      tick();
      chk("zero_irq_t2", {63'd0, irq}, 64'd1);
      chk("zero_req_valid_t2", {63'd0, req_valid}, 64'd0);
      tick();
      chk("zero_status", {56'd0, status_val}, 64'h02);
      chk("zero_irqs", 64'(irq_cnt - irq0), 64'd1);

      // Backpressure with operand and result wrap
      push_req(32'hFFFF_FFFF, 16'd0); push_req(32'h0000_0000, 16'd1);
      job_q.push_back(32'd0);
      do_start(16'd2, 32'hFFFF_FFFF);
      serve(2, 32'h8000_0000, 32'd0, 1'b0, 5);
      tick();
      chk("bp_status", {56'd0, status_val}, 64'h02);
      chk("bp_result", {32'd0, result}, 64'd0);

      // start_pulse while busy is ignored
      push_req(32'h100, 16'd0); push_req(32'h101, 16'd1);
      job_q.push_back(32'd10);
      irq0 = irq_cnt;
      do_start(16'd2, 32'h100);
      ctrl_val = 16'd5; data_val = 32'h200; start_pulse = 1'b1;
      tick();
      start_pulse = 1'b0;
      chk("busy_start_data", {32'd0, req_data}, 64'h100);
      serve(2, 32'd5, 32'd0, 1'b0, 0);
      tick();
      chk("busy_start_status", {56'd0, status_val}, 64'h02);
      chk("busy_start_irqs", 64'(irq_cnt - irq0), 64'd1);

      // Errors on every response: err_cnt saturates
      for (int i = 0; i < 9; i++) push_req(DATA_W'(i), CNT_W'(i));
      job_q.push_back(32'd9);
      do_start(16'd9, 32'd0);
      serve(9, 32'd1, 32'd0, 1'b1, 0);
      tick();
      chk("err_status", {56'd0, status_val}, 64'hE6);
      chk("err_result", {32'd0, result}, 64'd9);

      // Abort in WAIT after two responses
      push_req(32'h20, 16'd0); push_req(32'h21, 16'd1); push_req(32'h22, 16'd2);
      irq0 = irq_cnt;
      do_start(16'd4, 32'h20);
      serve(2, 32'd5, 32'd0, 1'b0, 0);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_req_valid", {63'd0, req_valid}, 64'd0);
      chk("abort_status", {56'd0, status_val}, 64'h10);
      chk("abort_result", {32'd0, result}, 64'd10);
      tick(); tick();
      chk("abort_status_hold", {56'd0, status_val}, 64'h10);
      chk("abort_irqs", 64'(irq_cnt - irq0), 64'd0);
      push_req(32'h30, 16'd0);
      job_q.push_back(32'd7);
      do_start(16'd1, 32'h30);
      chk("restart_status", {56'd0, status_val}, 64'h01);
      serve(1, 32'd7, 32'd0, 1'b0, 0);
      tick();
      chk("restart_done", {56'd0, status_val}, 64'h02);

`ifdef REGS_SEQ_TIMEOUT_EN
      // No response: irq 8 cycles after WAIT entry
      push_req(32'd0, 16'd0);
      job_q.push_back(32'd0);
      do_start(16'd1, 32'd0);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      begin
         int k;
         for (k = 1; k <= 20; k++) begin
            tick();
            if (irq) break;
         end
         chk("to_latency", 64'(k), 64'd8);
      end
      tick();
      chk("to_status", {56'd0, status_val}, 64'h0E);

      // Response on the expiry cycle wins
      push_req(32'd0, 16'd0);
      job_q.push_back(32'd3);
      do_start(16'd1, 32'd0);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      repeat (7) tick();
      rsp_valid = 1'b1; rsp_data = 32'd3;
      tick();
      rsp_valid = 1'b0; rsp_data = '0;
      chk("to_race_irq", {63'd0, irq}, 64'd1);
      tick();
      chk("to_race_status", {56'd0, status_val}, 64'h02);
`endif

      // Reset during ISSUE
      do_start(16'd3, 32'h40);
      chk("rst_mid_req_valid_pre", {63'd0, req_valid}, 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("rst_mid_req_valid", {63'd0, req_valid}, 64'd0);
      chk("rst_mid_status", {56'd0, status_val}, 64'd0);
      chk("rst_mid_irq", {63'd0, irq}, 64'd0);
      #1 rst = 1'b1;
      tick();
      chk("rst_mid_status_after", {56'd0, status_val}, 64'd0);
      tick();

      chk("req_q_empty", 64'(req_q.size()), 64'd0);
      chk("job_q_empty", 64'(job_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
